// File: rtl/guess_scanner.sv
// Hangman guess scanner: walks the stored word once per accepted guess and updates the reveal mask,
// the miss count and the solved/hung flags. Optional build macro GUESS_HISTORY_EN adds a used-letter register.
module guess_scanner #(
    parameter int MAX_LEN  = 16,
    parameter int CHAR_W   = 5,
    parameter int MAX_MISS = 9,
    localparam int AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                new_word,
    input  logic [4:0]          word_len,
    input  logic                try,
    input  logic [CHAR_W-1:0]   guess,
    output logic [AW-1:0]       rd_addr,
    input  logic [CHAR_W-1:0]   rd_data,
    output logic                busy,
    output logic                done,
    output logic                match,
    output logic [4:0]          new_hits,
    output logic                repeat_guess,
    output logic [MAX_LEN-1:0]  reveal_mask,
    output logic [3:0]          miss_count,
    output logic                solved,
    output logic                hung
);

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, RESULT, REPEAT} state_t;

    localparam logic [5:0] MAX_LEN_W = 6'(MAX_LEN);

    state_t               state_reg, state_next;
    logic [5:0]           len;
    logic [5:0]           last_reg;
    logic [CHAR_W-1:0]    guess_reg;
    logic [AW-1:0]        addr_reg;
    logic                 cmp_valid_reg;
    logic [AW-1:0]        cmp_pos_reg;
    logic                 any_eq_reg;
    logic [4:0]           hits_reg;
    logic [MAX_LEN-1:0]   mask_reg;
    logic [3:0]           miss_reg;
    logic [MAX_LEN-1:0]   len_mask;
    logic                 accept;
    logic                 is_repeat;
    logic                 at_last;
    logic                 hit_now;

    assign len = ({1'b0, word_len} > MAX_LEN_W) ? MAX_LEN_W : {1'b0, word_len};

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_len_mask
            assign len_mask[gi] = (6'(gi) < len);
        end
    endgenerate

    assign solved  = (len != 6'd0) && ((mask_reg & len_mask) == len_mask);
    assign hung    = (miss_reg == 4'(MAX_MISS));
    assign accept  = (state_reg == IDLE) && try && !new_word && (len != 6'd0) && !solved && !hung;
    assign at_last = (6'(addr_reg) == last_reg);
    // Compare stage sees the data for the address issued one cycle earlier.
    assign hit_now = cmp_valid_reg && (rd_data == guess_reg);

`ifdef GUESS_HISTORY_EN
    localparam logic [CHAR_W-1:0] NUM_LETTERS = CHAR_W'(26);
    logic [25:0] used_reg;

    assign is_repeat = (guess < NUM_LETTERS) && used_reg[guess];

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            used_reg <= '0;
        end else if (new_word) begin
            used_reg <= '0;
        end else if (state_reg == RESULT && guess_reg < NUM_LETTERS) begin
            used_reg[guess_reg] <= 1'b1;
        end
    end
`else
    assign is_repeat = 1'b0;
`endif

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (new_word) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (accept) state_next = is_repeat ? REPEAT : SCAN;
                SCAN:    if (at_last) state_next = DRAIN;
                DRAIN:   state_next = RESULT;
                RESULT:  state_next = IDLE;
                REPEAT:  state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        busy         = (state_reg != IDLE);
        done         = 1'b0;
        match        = 1'b0;
        new_hits     = '0;
        repeat_guess = 1'b0;
        if (!new_word) begin
            if (state_reg == RESULT) begin
                done     = 1'b1;
                match    = any_eq_reg;
                new_hits = hits_reg;
            end
            if (state_reg == REPEAT) begin
                done         = 1'b1;
                repeat_guess = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            last_reg      <= '0;
            guess_reg     <= '0;
            addr_reg      <= '0;
            cmp_valid_reg <= 1'b0;
            cmp_pos_reg   <= '0;
            any_eq_reg    <= 1'b0;
            hits_reg      <= '0;
            mask_reg      <= '0;
            miss_reg      <= '0;
        end else if (new_word) begin
            cmp_valid_reg <= 1'b0;
            any_eq_reg    <= 1'b0;
            hits_reg      <= '0;
            mask_reg      <= '0;
            miss_reg      <= '0;
        end else begin
            cmp_valid_reg <= (state_reg == SCAN);
            cmp_pos_reg   <= addr_reg;
            if (accept) begin
                guess_reg <= guess;
            end
            if (accept && !is_repeat) begin
                addr_reg   <= '0;
                last_reg   <= len - 6'd1;
                any_eq_reg <= 1'b0;
                hits_reg   <= '0;
            end else if (state_reg == SCAN && !at_last) begin
                addr_reg <= addr_reg + 1'b1;
            end
            if (hit_now) begin
                any_eq_reg <= 1'b1;
                if (!mask_reg[cmp_pos_reg]) begin
                    mask_reg[cmp_pos_reg] <= 1'b1;
                    hits_reg              <= hits_reg + 5'd1;
                end
            end
            if (state_reg == RESULT && !any_eq_reg && miss_reg != 4'(MAX_MISS)) begin
                miss_reg <= miss_reg + 4'd1;
            end
        end
    end

    assign rd_addr     = addr_reg;
    assign reveal_mask = mask_reg;
    assign miss_count  = miss_reg;

endmodule

// File: tb/tb_guess_scanner.sv
// Scoreboard bench for guess_scanner: a behavioural hangman model queues expected results per guess
// and each scenario task checks the DUT's done pulse, flags and counters against it.
module tb_guess_scanner;

    localparam int MAX_LEN  = 16;
    localparam int CHAR_W   = 5;
    localparam int MAX_MISS = 9;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        new_word = 1'b0;
    logic [4:0]  word_len = 5'd0;
    logic        try = 1'b0;
    logic [4:0]  guess = 5'd0;
    logic [3:0]  rd_addr;
    logic [4:0]  rd_data;
    logic        busy, done, match, repeat_guess, solved, hung;
    logic [4:0]  new_hits;
    logic [15:0] reveal_mask;
    logic [3:0]  miss_count;

    guess_scanner #(.MAX_LEN(MAX_LEN), .CHAR_W(CHAR_W), .MAX_MISS(MAX_MISS)) dut (
        .clk(clk), .resetn(resetn), .new_word(new_word), .word_len(word_len),
        .try(try), .guess(guess), .rd_addr(rd_addr), .rd_data(rd_data),
        .busy(busy), .done(done), .match(match), .new_hits(new_hits),
        .repeat_guess(repeat_guess), .reveal_mask(reveal_mask),
        .miss_count(miss_count), .solved(solved), .hung(hung)
    );

    always #5 clk = ~clk;

    logic [4:0] mem [16];
    always @(posedge clk) rd_data <= mem[rd_addr];

    int checks = 0;
    int failures = 0;

    logic [15:0] m_mask;
    int          m_miss;
    logic [25:0] m_used;
    int          m_len;

    typedef struct {
        logic       mt;
        logic [4:0] hits;
        logic       rep;
        logic [15:0] mask;
        int         miss;
        int         lat;
    } exp_t;
    exp_t sb[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_solved();
        if (m_len == 0) return 1'b0;
        for (int i = 0; i < m_len; i++) if (!m_mask[i]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = 5'd31;
    endtask

    task automatic start_word(input int n);
        @(negedge clk);
        word_len = 5'(n);
        new_word = 1'b1;
        @(negedge clk);
        new_word = 1'b0;
        m_mask = '0;
        m_miss = 0;
        m_used = '0;
        m_len  = (n > MAX_LEN) ? MAX_LEN : n;
    endtask

    // Called at a falling edge; drives one try and scores the resulting transaction.
    task automatic guess_once(input logic [4:0] g);
        exp_t e;
        bit ignored, rep, mt, got, busy_seen;
        int hits, lat, budget;
        logic obs_match, obs_rep;
        logic [4:0] obs_hits;
        logic [15:0] obs_mask;
        rep = 0; mt = 0; got = 0; busy_seen = 0; hits = 0; lat = -1;
        obs_match = 0; obs_rep = 0; obs_hits = 0; obs_mask = 0;
        ignored = (m_len == 0) || m_solved() || (m_miss == MAX_MISS);
        if (!ignored) begin
`ifdef GUESS_HISTORY_EN
            if (g < 26 && m_used[g]) rep = 1;
`endif
            if (!rep) begin
                for (int i = 0; i < m_len; i++) begin
                    if (mem[i] == g) begin
                        mt = 1;
                        if (!m_mask[i]) begin hits++; m_mask[i] = 1'b1; end
                    end
                end
                if (!mt && m_miss < MAX_MISS) m_miss++;
                if (g < 26) m_used[g] = 1'b1;
            end
            e.mt = mt; e.hits = 5'(hits); e.rep = rep; e.mask = m_mask;
            e.miss = m_miss; e.lat = rep ? 1 : m_len + 2;
            sb.push_back(e);
        end
        budget = m_len + 6;
        guess = g;
        try = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c == 1) try = 1'b0;
            if (busy) busy_seen = 1;
            if (done) begin
                got = 1; lat = c;
                obs_match = match; obs_hits = new_hits; obs_rep = repeat_guess; obs_mask = reveal_mask;
                break;
            end
        end
        if (ignored) begin
            checks++;
            if (got !== 1'b0 || busy_seen !== 1'b0) begin
                failures++;
                $display("FAIL ignored_try g=%0d: done=%0b busy=%0b, required done=0 busy=0", g, got, busy_seen);
            end
            $display("guess %0d: ignored (done=%0b busy=%0b)", g, got, busy_seen);
        end else if (!got) begin
            e = sb.pop_front();
            checks++; failures++;
            $display("FAIL done_timeout g=%0d: no done within %0d cycles, required at %0d", g, budget, e.lat);
        end else begin
            e = sb.pop_front();
            $display("guess %0d: done@T+%0d match=%0b hits=%0d rep=%0b mask=%h", g, lat, obs_match, obs_hits, obs_rep, obs_mask);
            checks++;
            if (lat != e.lat) begin failures++; $display("FAIL latency g=%0d: got %0d required %0d", g, lat, e.lat); end
            checks++;
            if (obs_match !== e.mt) begin failures++; $display("FAIL match g=%0d: got %0b required %0b", g, obs_match, e.mt); end
            checks++;
            if (obs_hits !== e.hits) begin failures++; $display("FAIL new_hits g=%0d: got %0d required %0d", g, obs_hits, e.hits); end
            checks++;
            if (obs_rep !== e.rep) begin failures++; $display("FAIL repeat_guess g=%0d: got %0b required %0b", g, obs_rep, e.rep); end
            checks++;
            if (obs_mask !== e.mask) begin failures++; $display("FAIL reveal_mask g=%0d: got %h required %h", g, obs_mask, e.mask); end
            @(negedge clk);
            checks++;
            if (miss_count !== 4'(e.miss)) begin failures++; $display("FAIL miss_count g=%0d: got %0d required %0d", g, miss_count, e.miss); end
            checks++;
            if (hung !== (e.miss == MAX_MISS) || solved !== m_solved()) begin
                failures++;
                $display("FAIL flags g=%0d: hung=%0b solved=%0b required hung=%0b solved=%0b", g, hung, solved, (e.miss == MAX_MISS), m_solved());
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 0 || done !== 0 || reveal_mask !== 0 || miss_count !== 0 || rd_addr !== 0) begin
            failures++;
            $display("FAIL reset_hold: busy=%0b done=%0b mask=%h miss=%0d addr=%0d required all 0", busy, done, reveal_mask, miss_count, rd_addr);
        end
        resetn = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 0 || done !== 0 || match !== 0 || new_hits !== 0 || repeat_guess !== 0 ||
            solved !== 0 || hung !== 0 || reveal_mask !== 0 || miss_count !== 0 || rd_addr !== 0) begin
            failures++;
            $display("FAIL reset_values: busy=%0b done=%0b match=%0b hits=%0d rep=%0b solved=%0b hung=%0b required all 0",
                     busy, done, match, new_hits, repeat_guess, solved, hung);
        end
        $display("reset: outputs checked");
    endtask

    task automatic test_basic();
        clear_mem();
        mem[0] = 5'd2; mem[1] = 5'd0; mem[2] = 5'd1;
        start_word(3);
        guess_once(5'd0);
        checks++;
        if (reveal_mask !== 16'h0002 || miss_count !== 4'd0 || rd_addr !== 4'd2) begin
            failures++;
            $display("FAIL cab_first: mask=%h miss=%0d addr=%0d required mask=0002 miss=0 addr=2", reveal_mask, miss_count, rd_addr);
        end
        guess_once(5'd0);
        guess_once(5'd30);
        guess_once(5'd25);
    endtask

    task automatic test_solve();
        clear_mem();
        mem[0] = 5'd0; mem[1] = 5'd0; mem[2] = 5'd1;
        start_word(3);
        guess_once(5'd0);
        guess_once(5'd1);
        checks++;
        if (solved !== 1'b1 || reveal_mask !== 16'h0007) begin
            failures++;
            $display("FAIL aab_solved: solved=%0b mask=%h required solved=1 mask=0007", solved, reveal_mask);
        end
        guess_once(5'd2);
        for (int i = 0; i < 16; i++) mem[i] = 5'd4;
        start_word(20);
        guess_once(5'd4);
    endtask

    task automatic test_hang();
        clear_mem();
        mem[0] = 5'd2; mem[1] = 5'd0; mem[2] = 5'd1;
        start_word(3);
        for (int g = 3; g <= 11; g++) guess_once(5'(g));
        checks++;
        if (hung !== 1'b1 || miss_count !== 4'd9) begin
            failures++;
            $display("FAIL hang: hung=%0b miss=%0d required hung=1 miss=9", hung, miss_count);
        end
        guess_once(5'd12);
    endtask

    task automatic test_abort();
        bit seen;
        clear_mem();
        for (int i = 0; i < 8; i++) mem[i] = 5'(i + 4);
        start_word(8);
        guess_once(5'd4);
        guess_once(5'd20);
        guess = 5'd5;
        try = 1'b1;
        @(negedge clk);
        try = 1'b0;
        @(negedge clk);
        new_word = 1'b1;
        @(negedge clk);
        new_word = 1'b0;
        checks++;
        if (busy !== 0 || reveal_mask !== 0 || miss_count !== 0) begin
            failures++;
            $display("FAIL abort_clear: busy=%0b mask=%h miss=%0d required 0 0 0", busy, reveal_mask, miss_count);
        end
        seen = 0;
        for (int c = 0; c < 12; c++) begin @(negedge clk); if (done || busy) seen = 1; end
        checks++;
        if (seen !== 1'b0) begin failures++; $display("FAIL abort_nodone: done/busy seen after abort, required none"); end
        $display("abort: mid-scan new_word handled");
        m_mask = '0; m_miss = 0; m_used = '0;
        guess_once(5'd6);
        guess_once(5'd21);
        guess = 5'd7;
        try = 1'b1;
        new_word = 1'b1;
        @(negedge clk);
        try = 1'b0;
        new_word = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin @(negedge clk); if (done || busy) seen = 1; end
        checks++;
        if (seen !== 1'b0 || reveal_mask !== 0 || miss_count !== 0) begin
            failures++;
            $display("FAIL try_and_new_word: seen=%0b mask=%h miss=%0d required 0 0 0", seen, reveal_mask, miss_count);
        end
        $display("abort: simultaneous try/new_word handled");
        m_mask = '0; m_miss = 0; m_used = '0;
        guess_once(5'd7);
    endtask

    task automatic test_repeat();
        clear_mem();
        mem[0] = 5'd2; mem[1] = 5'd0; mem[2] = 5'd1;
        start_word(3);
        guess_once(5'd7);
        guess_once(5'd7);
        checks++;
`ifdef GUESS_HISTORY_EN
        if (miss_count !== 4'd1) begin failures++; $display("FAIL repeat_miss: got %0d required 1", miss_count); end
`else
        if (miss_count !== 4'd2) begin failures++; $display("FAIL repeat_miss: got %0d required 2", miss_count); end
`endif
    endtask

    task automatic test_async_reset();
        clear_mem();
        mem[0] = 5'd2; mem[1] = 5'd0; mem[2] = 5'd1;
        start_word(3);
        guess_once(5'd2);
        guess_once(5'd20);
        guess = 5'd0;
        try = 1'b1;
        @(negedge clk);
        try = 1'b0;
        @(negedge clk);
        #2;
        resetn = 1'b1;
        #1;
        checks++;
        if (busy !== 0 || done !== 0 || rd_addr !== 0 || reveal_mask !== 0 || miss_count !== 0) begin
            failures++;
            $display("FAIL async_reset: busy=%0b done=%0b addr=%0d mask=%h miss=%0d required all 0",
                     busy, done, rd_addr, reveal_mask, miss_count);
        end
        $display("async reset: outputs cleared between edges");
        @(negedge clk);
        resetn = 1'b0;
        m_mask = '0; m_miss = 0; m_used = '0;
        guess_once(5'd0);
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_basic();
        test_solve();
        test_hang();
        test_abort();
        test_repeat();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/guess_scanner.md
# guess_scanner

Sequences the stored-word register file for one hangman guess. On each accepted `try`, it scans every stored character position against the guessed letter and updates a per-position reveal mask. It also keeps the miss count and flags solved/hung for the top-level game FSM. The block sits between the game controller (which pulses `new_word`/`try` and reads `done`) and the word memory/display datapath (which consumes `rd_addr`, `reveal_mask`, `miss_count`).

## Interface
- `MAX_LEN`, 16, word storage depth and reveal mask width (≤ 32)
- `CHAR_W`, 5, letter code width; legal letters 0–25
- `MAX_MISS`, 9, misses that complete the gallows drawing
- `clk` input 1 — single clock, rising edge
- `resetn` input 1 — asynchronous, active-high reset (asserted = 1, despite name)
- `new_word` input 1 — pulse: clear mask, misses, history; abort any scan
- `word_len` input 5 — stored word length; values > MAX_LEN clamp to MAX_LEN
- `try` input 1 — pulse: accept `guess` when idle
- `guess` input CHAR_W — guessed letter, sampled on accepted `try`
- `rd_addr` output $clog2(MAX_LEN) — word memory read address
- `rd_data` input CHAR_W — word memory data, valid 1 cycle after `rd_addr`
- `busy` output 1 — scan in progress
- `done` output 1 — one-cycle pulse, result valid
- `match` output 1 — guess occurs ≥1 time in word (valid with `done`)
- `new_hits` output 5 — positions newly revealed by this guess (valid with `done`)
- `repeat_guess` output 1 — guess rejected as already tried (GUESS_HISTORY_EN only, else 0)
- `reveal_mask` output MAX_LEN — bit i set = position i revealed
- `miss_count` output 4 — misses so far, saturates at MAX_MISS
- `solved` output 1 — all positions [word_len-1:0] revealed, word_len ≠ 0
- `hung` output 1 — miss_count == MAX_MISS

## Operation
- Reset values: all outputs 0, state IDLE, latched guess 0.
- States:
  - IDLE:
    - `try` with `word_len`≠0, !solved, !hung: latch guess, idx=0, clear hit accumulators, go to SCAN.
    - Otherwise `try` is ignored.
  - SCAN: drive `rd_addr`=idx, idx++. After issuing idx=len-1, go to DRAIN.
  - Compare stage: runs one cycle behind the issue. The position is the delayed idx. If `rd_data`==guess, set `any_eq`. If its mask bit is clear, set the bit and increment `new_hits`.
  - DRAIN: compare the final position, then go to RESULT.
  - RESULT:
    - `done`=1, `match`=`any_eq`.
    - If !`any_eq`, `miss_count`++ (saturating).
    - Go to IDLE.
- `busy`=1 in SCAN, DRAIN, RESULT.
- A repeated correct letter gives `match`=1, `new_hits`=0, and no miss.
- `solved` and `hung` are combinational from the mask, length and misses. Once either is set, `try` is ignored until `new_word`.
- `new_word` has priority over everything, in any state:
  - clears mask, misses, history and accumulators;
  - returns to IDLE;
  - suppresses `done` that cycle.
- `try` while busy is ignored and not queued.
- `try` and `new_word` in the same cycle: `new_word` wins; the `try` is dropped.
- A `guess` ≥ 26 is scanned normally and never matches (counts as a miss).

## Timing
- Accepted `try` in cycle T:
  - addresses issued T+1..T+len;
  - compares in T+2..T+len+1;
  - `done` in cycle T+len+2.
- `reveal_mask` bits update at the compare cycle. They are stable and final when `done` asserts.
- `miss_count` updates in the cycle after `done` is registered, i.e. visible at T+len+3.
- The next `try` can be accepted in T+len+3 (IDLE).
- `rd_addr` holds its last value outside SCAN.

## Configuration
- `GUESS_HISTORY_EN` defined:
  - A 26-bit used-letter register is set at RESULT, for guesses < 26 only, and cleared by `new_word`/reset.
  - A `try` whose letter is already used skips the scan. It produces `done`=1, `repeat_guess`=1, `match`=0, `new_hits`=0 at T+1, with no miss.
- Undefined:
  - No history register; `repeat_guess` is tied 0.
  - Every guess is scanned, and a repeated wrong letter counts as another miss.

## Test plan
- Word "CAB" (2,0,1), len 3; `try` guess 0 at T → `done` at T+5, `match`=1, `new_hits`=1, `reveal_mask`=3'b010, miss 0.
- Word "AAB" (0,0,1); guess 0 → `new_hits`=2, mask 3'b011. Then guess 1 → mask 3'b111, `solved`=1. A further `try` → no `busy`, no `done`.
- Nine guesses of letters absent from the word (distinct) → `miss_count`=9, `hung`=1. A tenth `try` is ignored.
- `new_word` in the second SCAN cycle → no `done`, `busy`=0 next cycle, mask/miss 0. `try` and `new_word` in the same cycle → only the clear occurs.
- Repeat wrong guess 7 twice:
  - with `GUESS_HISTORY_EN`, the second gives `repeat_guess`=1 at T+1 and miss stays 1;
  - without it, miss becomes 2.
- Async reset asserted mid-scan, between clock edges → all outputs 0 immediately; `try` is accepted the cycle after release.
